sys_controller: RTL

SYS_CONTROLLER -- requirements
Module: sys_controller

---
 rtl/sys_controller_pkg.sv | 18 +
 rtl/sys_ctrl_cnt.sv | 36 +++
 rtl/sys_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sys_controller_pkg.sv
// Shared configuration for the systolic-array controller: array geometry, datapath widths
// and the controller FSM state type.
package Config;

  localparam int unsigned sys_rows   = 6;
  localparam int unsigned sys_cols   = 3;
  localparam int unsigned W_BITWIDTH = 8;
  localparam int unsigned P_BITWIDTH = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StStream,
    StDrain,
    StDone
  } ctrl_state_e;

endpackage

// File: rtl/sys_ctrl_cnt.sv
// Clearable up-counter with enable and a terminal-count compare against a run-time value.
module sys_ctrl_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] tc_val_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/sys_controller.sv
// Job sequencer for a systolic array: weight load, activation stream, result drain.
// Define WEIGHT_REUSE_EN to add reuse_w_i, letting a job skip the weight load.
module sys_controller
  import Config::*;
#(
  parameter  int unsigned MAX_VEC = 256,
  localparam int unsigned VEC_W   = $clog2(MAX_VEC + 1),
  localparam int unsigned ROW_W   = $clog2(sys_rows)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
`ifdef WEIGHT_REUSE_EN
  input  logic             reuse_w_i,
`endif
  input  logic [VEC_W-1:0] num_vectors_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             w_load_en_o,
  output logic [ROW_W-1:0] w_row_sel_o,
  output logic             act_valid_o,
  output logic [VEC_W-1:0] act_idx_o,
  output logic             res_valid_o,
  output logic [VEC_W-1:0] res_idx_o,
  output logic             done_o
);

  localparam int unsigned LAT = sys_rows + sys_cols - 1;

  ctrl_state_e      state_q, state_d;
  logic [VEC_W-1:0] n_q, n_d;
  logic [LAT-2:0]   pipe_q, pipe_d;
  logic ready_q, ready_d, w_load_en_q, w_load_en_d, act_valid_q, act_valid_d;
  logic res_valid_q, res_valid_d, done_q, done_d;
  logic row_tc, act_tc, res_tc, skip_load;
  logic [ROW_W-1:0] row_cnt;
  logic [VEC_W-1:0] act_cnt, res_cnt;

`ifdef WEIGHT_REUSE_EN
  logic wl_q, wl_d;
  assign skip_load = reuse_w_i & wl_q;

  always_comb begin
    wl_d = wl_q;
    if (state_q == StLoadW) begin
      if (abort_i) begin
        wl_d = 1'b0;
      end else if (row_tc) begin
        wl_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wl_q <= 1'b0;
    end else begin
      wl_q <= wl_d;
    end
  end
`else
  assign skip_load = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          n_d = num_vectors_i;
          if (skip_load) begin
            state_d = (num_vectors_i == '0) ? StDone : StStream;
          end else begin
            state_d = StLoadW;
          end
        end
      end
      StLoadW:  if (row_tc) state_d = (n_q == '0) ? StDone : StStream;
      StStream: if (act_tc) state_d = StDrain;
      StDrain:  if (res_valid_q && res_tc) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort_i) state_d = StIdle;
  end

  // Outputs are decoded from the next state so they line up with state_q in the same cycle.
  always_comb begin
    ready_d     = (state_d == StIdle);
    w_load_en_d = (state_d == StLoadW);
    act_valid_d = (state_d == StStream);
    done_d      = (state_d == StDone);
    pipe_d      = (state_d == StIdle) ? '0 : ((pipe_q << 1) | (LAT - 1)'(act_valid_q));
    res_valid_d = pipe_q[LAT-2] && (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      n_q         <= '0;
      pipe_q      <= '0;
      ready_q     <= 1'b1;
      w_load_en_q <= 1'b0;
      act_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      pipe_q      <= pipe_d;
      ready_q     <= ready_d;
      w_load_en_q <= w_load_en_d;
      act_valid_q <= act_valid_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  sys_ctrl_cnt #(.Width(ROW_W)) u_row_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_d != StLoadW),
    .en_i     (state_q == StLoadW),
    .tc_val_i (ROW_W'(sys_rows - 1)),
    .cnt_o    (row_cnt),
    .tc_o     (row_tc)
  );

  sys_ctrl_cnt #(.Width(VEC_W)) u_act_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_d != StStream),
    .en_i     (state_q == StStream),
    .tc_val_i (n_q - VEC_W'(1)),
    .cnt_o    (act_cnt),
    .tc_o     (act_tc)
  );

  // Results span STREAM and DRAIN; the count advances on each issued result.
  sys_ctrl_cnt #(.Width(VEC_W)) u_res_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (!(state_d == StStream || state_d == StDrain)),
    .en_i     (res_valid_q),
    .tc_val_i (n_q - VEC_W'(1)),
    .cnt_o    (res_cnt),
    .tc_o     (res_tc)
  );

  assign ready_o     = ready_q;
  assign busy_o      = ~ready_q;
  assign w_load_en_o = w_load_en_q;
  assign w_row_sel_o = row_cnt;
  assign act_valid_o = act_valid_q;
  assign act_idx_o   = act_cnt;
  assign res_valid_o = res_valid_q;
  assign res_idx_o   = res_cnt;
  assign done_o      = done_q;

endmodule
